uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares one UART byte transmitter (tx_data/tx_start/tx_busy interface) among NUM_REQ byte-stream requesters, e.g. several auto-send message generators.
- Sits between the message sources and the UART TX core in the top level.
- Holds a grant for a whole packet (through the beat with req_last), inserts a programmable inter-packet gap, and aborts a packet whose source stalls too long.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- GAP_CYCLES, 16: idle clocks after a packet's last byte completes, before the next arbitration; 0 means no gap state.
- TIMEOUT_CYCLES, 50000: consecutive clocks in LOAD with the granted req_valid low before the packet is aborted (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*8  flattened bytes; requester i occupies [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a packet; qualified by valid.
- req_ready  out  NUM_REQ  per-requester byte accept.
- tx_data  out  8  byte presented to the UART TX core.
- tx_start  out  1  one-cycle start pulse to the UART TX core.
- tx_busy  in  1  from the UART TX core; high from the cycle after tx_start until the byte (stop bit included) is finished.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- grant_active  out  1  high from the grant until the packet finishes or aborts.
- abort  out  1  one-cycle pulse when a packet is aborted on timeout.

Behaviour:
- Reset values: req_ready=0, tx_data=8'h00, tx_start=0, grant_id=0, grant_active=0, abort=0.
  - Internal reset values: state=IDLE, RR pointer=0 (requester 0 has top priority), counters=0.
- Reset is synchronous, takes priority over everything and can occur mid-packet.
  - FSM is back in IDLE after the reset edge; no further tx_start is issued.
  - The UART core shares rst; the arbiter does not track a byte in flight.
- FSM states: IDLE, LOAD, START, WAIT, GAP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from the RR pointer upward with wrap.
  - Register grant_id, set grant_active=1, go to LOAD.
  - Requests are only sampled in IDLE; no preemption.
- LOAD:
  - req_ready[grant_id] = req_valid[grant_id]; all other req_ready bits are 0. req_ready is combinational from registered state.
  - On handshake: capture req_data slice into tx_data and req_last into last_q, clear the timeout counter, go to START.
  - With valid low: increment the timeout counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with valid still low: pulse abort, treat as packet end (see below).
- START: tx_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - The first WAIT cycle is the cycle after tx_start; tx_busy must be high there (core contract).
  - Remain while tx_busy=1. When tx_busy=0: if last_q, packet end; else go to LOAD.
- Packet end (last byte done, or abort):
  - grant_active=0; RR pointer = grant_id+1, wrapping at NUM_REQ.
  - Go to GAP if GAP_CYCLES>0, else to IDLE.
- GAP: count GAP_CYCLES clocks, then go to IDLE. Requests are held off (req_ready=0).
- Latency:
  - req_valid seen in IDLE at cycle 0 → grant_active and req_ready at cycle 1 → tx_start at cycle 2.
  - Between bytes of one packet: tx_busy falls in cycle n → req_ready in cycle n+1 → tx_start in cycle n+2.
- Simultaneous requests: lowest index at or above the pointer wins. Others keep their valid high and wait (they are not dropped).
- A single-byte packet is a beat with req_last=1 on its first handshake.
- req_valid/req_data/req_last of non-granted requesters are ignored.
- tx_data holds its value between bytes and after a packet.

Test Plan:
- Bench UART model: tx_busy high for 20 cycles after each tx_start.
- Single requester, single packet: req 0 sends 0x55,0xAA(last) → tx_start at cycle 2 with tx_data=0x55, then 0xAA.
  - Then 16 GAP cycles, grant_active=0, RR pointer=1.
- Simultaneous: req 1 and req 3 each send a 3-byte packet, both valid at the same edge after reset → order is all of req 1 (bytes 0x11,0x12,0x13), then all of req 3.
  - No interleaving; grant_id switches 1→3 only after the GAP.
- Round-robin fairness: all 4 requesters send continuous 1-byte packets → grant sequence 0,1,2,3,0,1… and tx_data equals each requester's byte in that order.
- Stall and timeout: req 2 sends byte 0x30 (not last), then drops valid.
  - With TIMEOUT_CYCLES=8: abort pulses after 8 LOAD cycles, grant_active falls the same cycle, and no further tx_start occurs for req 2's packet.
  - With valid restored after 5 stalled cycles, the packet completes normally and abort stays 0.
- Reset mid-packet: assert rst during WAIT of byte 2 of 4 → after the reset edge all outputs take their reset values.
  - A new request from req 3 then wins over pending req 1 only if req 3 is lower from pointer 0: expect req 1 granted first.
- GAP_CYCLES=0 build: back-to-back packets from req 0 and req 1 → req 1's grant_active rises the cycle after entering IDLE, i.e. 2 cycles after req 0's final tx_busy fall.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter sharing one UART byte transmitter among NUM_REQ requesters
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active,
  output logic                       abort
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CMAX = TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TO_END = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, GAP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, grant_id_q, grant_id_d, sel, idx, next_id;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic last_q, last_d, grant_active_q, grant_active_d, tx_start_q, abort_q, abort_d;
  logic hs, done;
  always_comb begin
    sel = ptr_q;
    idx = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (req_valid[idx]) sel = idx;
    end
  end
  assign hs = state_q == LOAD && req_valid[grant_id_q];
  assign next_id = (grant_id_q == IW'(NUM_REQ - 1)) ? '0 : grant_id_q + IW'(1);
  assign req_ready = (state_q == LOAD) ? req_valid & (NUM_REQ'(1) << grant_id_q) : '0;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_id_d = grant_id_q;
    cnt_d = cnt_q;
    tx_data_d = tx_data_q;
    last_d = last_q;
    grant_active_d = grant_active_q;
    abort_d = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE: if (|req_valid) begin
        state_d = LOAD;
        grant_id_d = sel;
        grant_active_d = 1'b1;
        cnt_d = '0;
      end
      LOAD: if (hs) begin
        tx_data_d = req_data[{grant_id_q, 3'b000} +: 8];
        last_d = req_last[grant_id_q];
        cnt_d = '0;
        state_d = START;
      end else if (cnt_q == TO_END) begin
        abort_d = 1'b1;
        done = 1'b1;
      end else cnt_d = cnt_q + CW'(1);
      START: state_d = WAIT;
      WAIT: if (!tx_busy) begin
        state_d = LOAD;
        done = last_q;
      end
      default: if (cnt_q == GAP_END) state_d = IDLE; else cnt_d = cnt_q + CW'(1);
    endcase
    if (done) begin
      grant_active_d = 1'b0;
      ptr_d = next_id;
      cnt_d = '0;
      state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_id_q <= '0;
      cnt_q <= '0;
      tx_data_q <= '0;
      last_q <= 1'b0;
      grant_active_q <= 1'b0;
      tx_start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_id_q <= grant_id_d;
      cnt_q <= cnt_d;
      tx_data_q <= tx_data_d;
      last_q <= last_d;
      grant_active_q <= grant_active_d;
      tx_start_q <= state_d == START;
      abort_q <= abort_d;
    end
  end
  assign tx_data = tx_data_q;
  assign tx_start = tx_start_q;
  assign grant_id = grant_id_q;
  assign grant_active = grant_active_q;
  assign abort = abort_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of grant order, gap, timeout, reset and zero-gap build
module tb_uart_tx_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] rv = '0, rl = '0;
  logic [63:0] rd = '0;
  logic [3:0] rdy_a, rdy_b;
  logic [7:0] txd_a, txd_b;
  logic [1:0] gid_a, gid_b, stcap;
  logic st_a, st_b, ga_a, ga_b, ab_a, ab_b;
  logic busy_a = 1'b0, busy_b = 1'b0;
  logic [7:0] hs;
  logic [8:0] q[8][$];
  logic [31:0] log_a[$], log_b[$];
  int cyc = 0, base = 0, n_chk = 0, n_pass = 0, aborts = 0, bc_a = 0, bc_b = 0;
  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(16), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst), .req_valid(rv[3:0]), .req_data(rd[31:0]), .req_last(rl[3:0]),
    .req_ready(rdy_a), .tx_data(txd_a), .tx_start(st_a), .tx_busy(busy_a),
    .grant_id(gid_a), .grant_active(ga_a), .abort(ab_a));
  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .rst(rst), .req_valid(rv[7:4]), .req_data(rd[63:32]), .req_last(rl[7:4]),
    .req_ready(rdy_b), .tx_data(txd_b), .tx_start(st_b), .tx_busy(busy_b),
    .grant_id(gid_b), .grant_active(ga_b), .abort(ab_b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask
  function automatic logic [31:0] ev(input int rel, input int id, input int d);
    logic [15:0] c;
    c = 16'(base + rel);
    return {c, 6'd0, id[1:0], d[7:0]};
  endfunction
  task automatic drive();
    for (int i = 0; i < 8; i++) begin
      rv[i] = q[i].size() > 0;
      if (q[i].size() > 0) {rl[i], rd[8*i +: 8]} = q[i][0];
    end
  endtask
  task automatic tick();
    @(posedge clk);
    hs = rst ? '0 : rv & {rdy_b, rdy_a};
    stcap = {st_b, st_a};
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 8; i++) if (hs[i]) void'(q[i].pop_front());
    drive();
    if (rst) begin
      bc_a = 0;
      bc_b = 0;
    end else begin
      bc_a = stcap[0] ? 20 : (bc_a > 0 ? bc_a - 1 : 0);
      bc_b = stcap[1] ? 20 : (bc_b > 0 ? bc_b - 1 : 0);
    end
    busy_a = bc_a != 0;
    busy_b = bc_b != 0;
    #1;
    if (st_a) log_a.push_back({cyc[15:0], 6'd0, gid_a, txd_a});
    if (st_b) log_b.push_back({cyc[15:0], 6'd0, gid_b, txd_b});
    if (ab_a) aborts++;
  endtask
  task automatic run_until(input int rel);
    while (cyc < base + rel) tick();
  endtask
  task automatic rst_pulse();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) q[i].delete();
    drive();
    tick();
    rst = 1'b0;
    log_a.delete();
    log_b.delete();
    aborts = 0;
    base = cyc;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    tick();
    tick();
    chk("rst_ready", 32'(rdy_a), 0);
    chk("rst_data", 32'(txd_a), 0);
    chk("rst_start", 32'(st_a), 0);
    chk("rst_gid", 32'(gid_a), 0);
    chk("rst_active", 32'(ga_a), 0);
    chk("rst_abort", 32'(ab_a), 0);
    rst = 1'b0;
    base = cyc;
    q[0].push_back({1'b0, 8'h55});
    q[0].push_back({1'b1, 8'hAA});
    drive();
    run_until(1);
    chk("t1_active", 32'(ga_a), 1);
    chk("t1_ready", 32'(rdy_a), 1);
    run_until(2);
    chk("t1_start", 32'(st_a), 1);
    chk("t1_data", 32'(txd_a), 32'h55);
    run_until(46);
    chk("t1_active_hold", 32'(ga_a), 1);
    run_until(47);
    chk("t1_active_fall", 32'(ga_a), 0);
    q[1].push_back({1'b1, 8'h21});
    q[0].push_back({1'b1, 8'h01});
    drive();
    run_until(50);
    chk("t1_gap_ready", 32'(rdy_a), 0);
    chk("t1_data_hold", 32'(txd_a), 32'hAA);
    run_until(63);
    chk("t1_gap_end", 32'(ga_a), 0);
    run_until(64);
    chk("t1_regrant", 32'(ga_a), 1);
    chk("t1_ptr", 32'(gid_a), 1);
    run_until(150);
    chk("t1_n", log_a.size(), 4);
    chk("t1_s0", log_a[0], ev(2, 0, 'h55));
    chk("t1_s1", log_a[1], ev(25, 0, 'hAA));
    chk("t1_s2", log_a[2], ev(65, 1, 'h21));
    chk("t1_s3", log_a[3], ev(105, 0, 'h01));
    rst_pulse();
    for (int b = 0; b < 3; b++) begin
      q[1].push_back({b == 2, 8'(8'h11 + b)});
      q[3].push_back({b == 2, 8'(8'h31 + b)});
    end
    drive();
    run_until(85);
    chk("t2_gid_gap", 32'(gid_a), 1);
    chk("t2_active_gap", 32'(ga_a), 0);
    run_until(87);
    chk("t2_gid_next", 32'(gid_a), 3);
    run_until(175);
    chk("t2_n", log_a.size(), 6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("t2_s%0d", k), log_a[k],
          ev(k < 3 ? 2 + 23 * k : 88 + 23 * (k - 3), k < 3 ? 1 : 3, (k < 3 ? 'h11 + k : 'h31 + k - 3)));
    rst_pulse();
    for (int i = 0; i < 4; i++) begin
      q[i].push_back({1'b1, 8'(8'hA0 + i)});
      q[i].push_back({1'b1, 8'(8'hB0 + i)});
    end
    drive();
    run_until(330);
    chk("t3_n", log_a.size(), 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t3_s%0d", k), log_a[k], ev(2 + 40 * k, k % 4, (k < 4 ? 'hA0 : 'hB0) + k % 4));
    rst_pulse();
    q[2].push_back({1'b0, 8'h30});
    drive();
    run_until(31);
    chk("t4_abort_pre", 32'(ab_a), 0);
    chk("t4_active_pre", 32'(ga_a), 1);
    run_until(32);
    chk("t4_abort", 32'(ab_a), 1);
    chk("t4_active_fall", 32'(ga_a), 0);
    run_until(33);
    chk("t4_abort_pulse", 32'(ab_a), 0);
    run_until(60);
    chk("t4_n", log_a.size(), 1);
    chk("t4_s0", log_a[0], ev(2, 2, 'h30));
    chk("t4_aborts", aborts, 1);
    rst_pulse();
    q[2].push_back({1'b0, 8'h30});
    drive();
    run_until(29);
    q[2].push_back({1'b1, 8'h31});
    drive();
    run_until(51);
    chk("t4b_active", 32'(ga_a), 1);
    run_until(52);
    chk("t4b_active_fall", 32'(ga_a), 0);
    run_until(60);
    chk("t4b_n", log_a.size(), 2);
    chk("t4b_s1", log_a[1], ev(30, 2, 'h31));
    chk("t4b_aborts", aborts, 0);
    rst_pulse();
    for (int b = 0; b < 4; b++) q[1].push_back({b == 3, 8'(8'h61 + b)});
    drive();
    run_until(30);
    rst = 1'b1;
    tick();
    chk("t5_ready", 32'(rdy_a), 0);
    chk("t5_data", 32'(txd_a), 0);
    chk("t5_start", 32'(st_a), 0);
    chk("t5_gid", 32'(gid_a), 0);
    chk("t5_active", 32'(ga_a), 0);
    chk("t5_abort", 32'(ab_a), 0);
    rst = 1'b0;
    q[3].push_back({1'b1, 8'h71});
    drive();
    run_until(130);
    chk("t5_n", log_a.size(), 5);
    chk("t5_s1", log_a[1], ev(25, 1, 'h62));
    chk("t5_s2", log_a[2], ev(33, 1, 'h63));
    chk("t5_s3", log_a[3], ev(56, 1, 'h64));
    chk("t5_s4", log_a[4], ev(96, 3, 'h71));
    rst_pulse();
    q[4].push_back({1'b1, 8'hC0});
    q[5].push_back({1'b1, 8'hC1});
    drive();
    run_until(24);
    chk("t6_idle", 32'(ga_b), 0);
    run_until(25);
    chk("t6_regrant", 32'(ga_b), 1);
    chk("t6_gid", 32'(gid_b), 1);
    run_until(60);
    chk("t6_n", log_b.size(), 2);
    chk("t6_s0", log_b[0], ev(2, 0, 'hC0));
    chk("t6_s1", log_b[1], ev(26, 1, 'hC1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
